// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetches one instruction word per transaction
// over a req/ack handshake, presents it for a single execute cycle, then
// advances or branches the program counter and counts retired instructions.
module fetch_ctrl #(
    parameter logic [3:0]  RESET_PC = 4'h0,
    parameter logic [10:0] NOOP_INS = 11'b01100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        stop,
    input  logic        zero,
    output logic        imem_req,
    output logic [3:0]  IMEM_ADDR,
    input  logic        imem_ack,
    input  logic [10:0] IMEM_DATA,
    output logic [10:0] INS,
    output logic        exec_en,
    output logic        busy,
    output logic [3:0]  PC,
    output logic [7:0]  RETIRED
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_pc;
    logic [3:0]  w_pc_next;
    logic [10:0] r_ins;
    logic [10:0] w_ins_next;
    logic [7:0]  r_retired;
    logic [7:0]  w_retired_next;
    logic        w_branch_taken;

    // Conditional branch: opcode 3'b100 jumps to the target field when zero is set.
    assign w_branch_taken = (r_ins[10:8] == 3'b100) && zero;

    // State register; synchronous reset overrides everything, including a pending ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_pc      <= RESET_PC;
            r_ins     <= NOOP_INS;
            r_retired <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_ins     <= w_ins_next;
            r_retired <= w_retired_next;
        end
    end

    // Next-state logic: handshake capture in FETCH, PC/retire update at the end of EXEC.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ins_next     = r_ins;
        w_retired_next = r_retired;
        case (r_state)
            StIdle: begin
                if (run) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    w_ins_next   = IMEM_DATA;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (r_retired != 8'hFF) begin
                    w_retired_next = r_retired + 8'h01;
                end
                // Branch target wins over the sequential increment, including at 4'hF.
                w_pc_next    = w_branch_taken ? r_ins[7:4] : r_pc + 4'h1;
                w_ins_next   = NOOP_INS;
                w_state_next = stop ? StIdle : StFetch;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decoded straight from the registered state.
    always_comb begin
        imem_req  = (r_state == StFetch);
        exec_en   = (r_state == StExec);
        busy      = (r_state == StFetch) || (r_state == StExec);
        IMEM_ADDR = r_pc;
        PC        = r_pc;
        INS       = r_ins;
        RETIRED   = r_retired;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [3:0]  RST_PC = 4'h0;
    localparam logic [10:0] NOOP   = 11'b01100000000;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        stop;
    logic        zero;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [10:0] imem_data;
    logic [10:0] ins;
    logic        exec_en;
    logic        busy;
    logic [3:0]  pc;
    logic [7:0]  retired;

    int n_checks;
    int n_errors;

    fetch_ctrl #(
        .RESET_PC (RST_PC),
        .NOOP_INS (NOOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .stop      (stop),
        .zero      (zero),
        .imem_req  (imem_req),
        .IMEM_ADDR (imem_addr),
        .imem_ack  (imem_ack),
        .IMEM_DATA (imem_data),
        .INS       (ins),
        .exec_en   (exec_en),
        .busy      (busy),
        .PC        (pc),
        .RETIRED   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a controller that is either stopped, waiting for an
    // instruction, or holding one for its single execute cycle.
    bit          m_running;
    bit          m_holding;
    int          m_pc;
    logic [10:0] m_ins;
    int          m_ret;

    task automatic model_step();
        if (!rst_n) begin
            m_running = 0;
            m_holding = 0;
            m_pc      = RST_PC;
            m_ins     = NOOP;
            m_ret     = 0;
        end else if (m_holding) begin
            m_ret = (m_ret < 255) ? m_ret + 1 : 255;
            if (m_ins[10:8] == 3'd4 && zero) m_pc = m_ins[7:4];
            else                             m_pc = (m_pc + 1) % 16;
            m_ins     = NOOP;
            m_holding = 0;
            m_running = !stop;
        end else if (m_running) begin
            if (imem_ack) begin
                m_ins     = imem_data;
                m_holding = 1;
            end
        end else if (run) begin
            m_running = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " imem_req"}, 32'(imem_req), 32'(m_running && !m_holding));
        chk({tag, " exec_en"},  32'(exec_en),  32'(m_holding));
        chk({tag, " busy"},     32'(busy),     32'(m_running));
        chk({tag, " addr"},     32'(imem_addr), 32'(m_pc));
        chk({tag, " pc"},       32'(pc),        32'(m_pc));
        chk({tag, " ins"},      32'(ins),       32'(m_ins));
        chk({tag, " retired"},  32'(retired),   32'(m_ret));
    endtask

    // Apply inputs, clock once, then compare against the model.
    task automatic cyc(input logic i_rst_n, input logic i_run, input logic i_stop,
                       input logic i_zero, input logic i_ack, input logic [10:0] i_data,
                       input string tag);
        rst_n     = i_rst_n;
        run       = i_run;
        stop      = i_stop;
        zero      = i_zero;
        imem_ack  = i_ack;
        imem_data = i_data;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    // Reset, start, and execute n plain instructions back to back (ends in FETCH).
    task automatic start_and_exec(input int n);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "seq rst");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, "seq run");
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, "seq fetch");
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "seq exec");
        end
    endtask

    typedef struct packed {
        logic        rst_n;
        logic        run;
        logic        stop;
        logic        zero;
        logic        ack;
        logic [10:0] data;
        logic        e_req;
        logic        e_exec;
        logic        e_busy;
        logic [3:0]  e_pc;
        logic [10:0] e_ins;
        logic [7:0]  e_ret;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        run       = 1'b0;
        stop      = 1'b0;
        zero      = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 11'h000;
        m_running = 0;
        m_holding = 0;
        m_pc      = RST_PC;
        m_ins     = NOOP;
        m_ret     = 0;

        //         rst   run   stop  zero  ack   data     req   exe   busy  pc    ins      ret
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0, 11'h300, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0, 11'h300, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 1'b1, 1'b0, 1'b1, 4'h0, 11'h300, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h0, 11'h300, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h0, 11'h300, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h0, 11'h300, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, 1'b0, 1'b1, 1'b1, 4'h0, 11'h011, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h1, 11'h300, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, 1'b0, 1'b1, 1'b1, 4'h1, 11'h011, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'h055, 1'b1, 1'b0, 1'b1, 4'h2, 11'h300, 8'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, 1'b0, 1'b1, 1'b1, 4'h2, 11'h011, 8'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h3, 11'h300, 8'd3};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h3, 11'h300, 8'd3};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, 1'b0, 1'b1, 1'b1, 4'h3, 11'h011, 8'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h4, 11'h300, 8'd4};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h4, 11'h300, 8'd4};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, 1'b0, 1'b0, 1'b0, 4'h0, 11'h300, 8'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0, 11'h300, 8'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h0, 11'h300, 8'd0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h460, 1'b0, 1'b1, 1'b1, 4'h0, 11'h460, 8'd0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 4'h6, 11'h300, 8'd1};

        // Directed table; the model is stepped alongside so later phases stay in sync.
        for (int i = 0; i < NVEC; i++) begin
            rst_n     = vecs[i].rst_n;
            run       = vecs[i].run;
            stop      = vecs[i].stop;
            zero      = vecs[i].zero;
            imem_ack  = vecs[i].ack;
            imem_data = vecs[i].data;
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d exec_en", i),  32'(exec_en),  32'(vecs[i].e_exec));
            chk($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
            chk($sformatf("vec%0d addr", i),     32'(imem_addr), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d pc", i),       32'(pc),        32'(vecs[i].e_pc));
            chk($sformatf("vec%0d ins", i),      32'(ins),       32'(vecs[i].e_ins));
            chk($sformatf("vec%0d retired", i),  32'(retired),   32'(vecs[i].e_ret));
        end

        // Taken branch at PC=F loads the target instead of wrapping.
        start_and_exec(15);
        chk("reach pc F", 32'(pc), 32'h0000000F);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h460, "br fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, "br exec z1");
        chk("branch taken at F", 32'(pc), 32'h00000006);

        // Same branch with zero=0 wraps to 0.
        start_and_exec(15);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h460, "br fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "br exec z0");
        chk("branch not taken at F", 32'(pc), 32'h00000000);

        // Non-branch at F wraps even with zero=1.
        start_and_exec(15);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, "nb fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, "nb exec");
        chk("wrap at F", 32'(pc), 32'h00000000);

        // Saturation of the retired counter.
        start_and_exec(260);
        chk("retired saturates", 32'(retired), 32'h000000FF);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h011, "sat fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "sat exec");
        chk("retired stays saturated", 32'(retired), 32'h000000FF);

        // Randomized traffic against the model.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, "rnd rst");
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic [10:0] r_data;
            r_rst  = ($urandom_range(0, 99) != 0);
            r_data = 11'($urandom);
            if ($urandom_range(0, 1) == 1) r_data[10:8] = 3'b100;
            cyc(r_rst, 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                1'($urandom), r_data, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
